// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types, constants and hex decode table for the seven-segment scanner
package sseg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam int         NUM_DIGITS      = 4;
    localparam logic [3:0] ANODE_ALL_OFF   = 4'hF;
    localparam logic [7:0] CATHODE_ALL_OFF = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; dp is left off here and cleared by the decoder.
    function automatic logic [7:0] hex_cathode(input logic [3:0] value);
        logic [7:0] seg;
        case (value)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// rtl/sseg_hex_decoder.sv - combinational {dp,hex} to active-low cathode pattern
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [4:0] digit,
    output logic [7:0] cathode
);

    always_comb begin
        cathode = hex_cathode(digit[3:0]);
        if (digit[4]) begin
            cathode[7] = 1'b0;
        end
    end

endmodule

// File: rtl/sseg_scan_scheduler.sv
// rtl/sseg_scan_scheduler.sv - two-port digit file with multiplexed 4-digit seven-segment scan
module sseg_scan_scheduler
    import sseg_pkg::*;
#(
    parameter int DWELL_CYCLES = 5000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] bright,
    input  logic       lz_en,
    input  logic       a_req,
    input  logic [1:0] a_idx,
    input  logic [4:0] a_data,
    output logic       a_ack,
    input  logic       b_req,
    input  logic [1:0] b_idx,
    input  logic [4:0] b_data,
    output logic       b_ack,
    output logic [3:0] sseg_anode,
    output logic [7:0] sseg_cathode,
    output logic       frame_done,
    output logic [1:0] cur_digit
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int TH_W    = $clog2(DWELL_CYCLES) + 4;
    localparam int CMP_W   = (CNT_W > TH_W) ? CNT_W : TH_W;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [TH_W-1:0]  DWELL_TH   = TH_W'(DWELL_CYCLES);

    logic                  last_grant_a;
    logic                  grant_a, grant_b;
    logic [4:0]            digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] supp_vec;
    logic                  zero_above;

    scan_state_t           state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [1:0]            digit_nxt;
    logic                  enter_show, frame_nxt;
    logic [4:0]            shadow_data;
    logic                  shadow_supp;

    logic [TH_W-1:0]       on_thresh;
    logic                  anode_on;
    logic [3:0]            anode_nxt;
    logic [7:0]            dec_cathode;

    // Round-robin between the two writers; reset leaves B as last winner so A goes first.
    assign grant_a = a_req & (~b_req | ~last_grant_a);
    assign grant_b = b_req & ~grant_a;
    assign a_ack   = grant_a;
    assign b_ack   = grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_a <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= 5'h00;
            end
        end else if (grant_a) begin
            digits[a_idx] <= a_data;
            last_grant_a  <= 1'b1;
        end else if (grant_b) begin
            digits[b_idx] <= b_data;
            last_grant_a  <= 1'b0;
        end
    end

    always_comb begin
        supp_vec   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above & (digits[i] == 5'h00);
            supp_vec[i] = lz_en & zero_above;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        digit_nxt  = cur_digit;
        enter_show = 1'b0;
        frame_nxt  = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            digit_nxt = 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt  = ST_SHOW;
                    cnt_nxt    = '0;
                    digit_nxt  = 2'd0;
                    enter_show = 1'b1;
                end
                ST_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt  = ST_SHOW;
                        cnt_nxt    = '0;
                        digit_nxt  = cur_digit + 2'd1;
                        enter_show = 1'b1;
                        frame_nxt  = (cur_digit == 2'(NUM_DIGITS - 1));
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    digit_nxt = 2'd0;
                end
            endcase
        end
    end

    // The shadow copy freezes the digit for its whole dwell, so mid-dwell writes never tear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur_digit   <= 2'd0;
            shadow_data <= 5'h00;
            shadow_supp <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_digit <= digit_nxt;
            if (enter_show) begin
                shadow_data <= digits[digit_nxt];
                shadow_supp <= supp_vec[digit_nxt];
            end
        end
    end

    assign on_thresh = ((TH_W'(bright) + TH_W'(1)) * DWELL_TH) >> 3;
    assign anode_on  = en && (state == ST_SHOW) && !shadow_supp &&
                       (CMP_W'(cnt) < CMP_W'(on_thresh));

    sseg_hex_decoder u_hex_decoder (
        .digit   (shadow_data),
        .cathode (dec_cathode)
    );

    always_comb begin
        anode_nxt = ANODE_ALL_OFF;
        if (anode_on) begin
            anode_nxt[cur_digit] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sseg_anode   <= ANODE_ALL_OFF;
            sseg_cathode <= CATHODE_ALL_OFF;
            frame_done   <= 1'b0;
        end else begin
            sseg_anode   <= anode_nxt;
            sseg_cathode <= anode_on ? dec_cathode : CATHODE_ALL_OFF;
            frame_done   <= frame_nxt;
        end
    end

endmodule

// File: doc/sseg_scan_scheduler.md
SSEG_SCAN_SCHEDULER -- requirements
Module: sseg_scan_scheduler

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, 5000, SHOW-state length per digit in clk cycles (10 kHz digit rate at 50 MHz clk); legal range >= 8.
REQ-002 SHALL have parameter BLANK_CYCLES, 16, anti-ghost blank length between digits; legal range >= 1.
REQ-003 SHALL have ports: clk  in  1  system clock, sole clock domain; reset is asynchronous and active-low, port rst_n  in  1.
REQ-004 SHALL have ports: en  in  1  scan enable; bright  in  3  brightness level 0..7; lz_en  in  1  leading-zero suppression enable.
REQ-005 SHALL have ports: a_req  in  1, a_idx  in  2, a_data  in  5, a_ack  out  1  requester A digit write (data[3:0] hex value, data[4] decimal point).
REQ-006 SHALL have ports: b_req  in  1, b_idx  in  2, b_data  in  5, b_ack  out  1  requester B, identical semantics.
REQ-007 SHALL have ports: sseg_anode  out  4  active-low digit enables; sseg_cathode  out  8  active-low segments {dp,g,f,e,d,c,b,a}; frame_done  out  1  end-of-frame pulse; cur_digit  out  2  digit index being scanned.

Function
REQ-008 SHALL hold a 4-entry x 5-bit digit register file written only through the arbiter.
REQ-009 SHALL grant at most one write per cycle: lone req is granted; with both reqs, the requester not granted last wins; last-grant resets to B, so A wins first.
REQ-010 SHALL drive ack combinationally high in the grant cycle; write commits on that clock edge; requester holds req/idx/data until ack and deasserts the cycle after ack, else the held req counts as a new request.
REQ-011 SHALL accept writes in every state, including en=0.
REQ-012 SHALL implement FSM IDLE, SHOW, BLANK; IDLE->SHOW when en=1 with cur_digit=0, cnt=0.
REQ-013 SHOW: cnt runs 0..DWELL_CYCLES-1, then ->BLANK with cnt=0.
REQ-014 BLANK: cnt runs 0..BLANK_CYCLES-1, then ->SHOW with cur_digit+1, wrapping 3->0.
REQ-015 SHALL pulse frame_done for exactly 1 cycle on the BLANK->SHOW transition leaving cur_digit=3.
REQ-016 On SHOW entry SHALL latch entry cur_digit into a shadow register plus its suppress flag; writes during SHOW appear on that digit's next visit.
REQ-017 on_thresh = ((bright+1)*DWELL_CYCLES)>>3, computed at clog2(DWELL_CYCLES)+4 bits, no truncation before the shift; bright=7 gives full dwell.
REQ-018 In SHOW, anode bit cur_digit SHALL be low iff cnt < on_thresh and suppress flag clear; all other anode bits high.
REQ-019 Cathode SHALL show full hex 0-F (0=C0,1=F9,2=A4,3=B0,4=99,...,F=8E) with bit7 cleared when dp=1; in BLANK/IDLE or when anode is off, cathode = 8'hFF.
REQ-020 With lz_en=1, digit i (1..3) SHALL be suppressed iff it and every higher digit have value 0 and dp 0; digit 0 never suppressed.
REQ-021 en=0 in any state SHALL force IDLE next cycle, cnt=0, cur_digit=0; no frame_done.
REQ-022 sseg_anode, sseg_cathode and frame_done SHALL be registered: one cycle after the FSM/counter state that produces them.

Reset
REQ-023 rst_n low SHALL asynchronously force: IDLE, cnt=0, cur_digit=0, last-grant=B, all digits 5'h00, sseg_anode=4'hF, sseg_cathode=8'hFF, frame_done=0.
REQ-024 Reset deassertion mid-operation SHALL restart scanning from digit 0 at the first en=1 edge; no partial-dwell output.

Structure
REQ-025 Package sseg_pkg SHALL hold the state enum, NUM_DIGITS=4, ALL_OFF constants (4'hF, 8'hFF) and the hex-to-cathode table.
REQ-026 Hex-to-cathode decode SHALL be sub-module sseg_hex_decoder (5-bit in, 8-bit out, combinational).

Verification
REQ-027 DWELL=8, BLANK=2, bright=7, digits 3..0 = 4,3,2,1 -> anode E(8 cycles), F(2), D, F, B, F, 7, F; cathode F9,A4,B0,99 in order; frame_done every 40 cycles.
REQ-028 DWELL=8, bright=3 -> on_thresh=4; anode low 4 of 8 SHOW cycles, cathode FF for the other 4.
REQ-029 a_req idx0 data 5 and b_req idx0 data 9 in the same cycle -> a_ack cycle 1 (digit0=5), b_ack cycle 2 (digit0=9).
REQ-030 lz_en=1, digits 3..0 = 0,0,7,0 -> anode bits 3,2 never low; digit1 shows F8, digit0 shows C0.
REQ-031 en dropped mid-SHOW on digit 2 -> anode 4'hF one cycle later; re-enable resumes at digit 0.
REQ-032 rst_n pulsed low mid-SHOW -> anode F, cathode FF, frame_done 0 without waiting for a clk edge; digits read back 0.
